// File: rtl/demux_scatter_reg.sv
// Two-channel registered scatter into operand banks A and B; presents a complete frame until acked.
// Optional DEMUX_SCATTER_RANGE_ERR_EN adds a sticky sel_err flag for out-of-range manual writes.
module demux_scatter_reg #(
    parameter int DW = 16,
    parameter int NA = 4,
    parameter int NB = 6,
    parameter int SA = 2,
    parameter int SB = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             auto_mode,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [SA-1:0]    a_sel,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [SB-1:0]    b_sel,
    input  logic [DW-1:0]    b_data,
    output logic [NA*DW-1:0] a_flat,
    output logic [NB*DW-1:0] b_flat,
    output logic [NA-1:0]    a_mask,
    output logic [NB-1:0]    b_mask,
    output logic             frame_valid,
    input  logic             frame_ack
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
    ,
    output logic             sel_err
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    logic [SA-1:0] a_ptr;
    logic [SB-1:0] b_ptr;
    logic [SA-1:0] a_idx;
    logic [SB-1:0] b_idx;
    logic          a_xfer;
    logic          b_xfer;
    logic [NA-1:0] a_mask_nxt;
    logic [NB-1:0] b_mask_nxt;

    assign a_ready     = (state == FILL);
    assign b_ready     = (state == FILL);
    assign frame_valid = (state == HOLD);

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;
    assign a_idx  = auto_mode ? a_ptr : a_sel;
    assign b_idx  = auto_mode ? b_ptr : b_sel;

    // Out-of-range indices simply match no element, so the write is dropped.
    always_comb begin
        a_mask_nxt = a_mask;
        for (int i = 0; i < NA; i++) begin
            if (a_xfer && (a_idx == SA'(i))) a_mask_nxt[i] = 1'b1;
        end
        b_mask_nxt = b_mask;
        for (int i = 0; i < NB; i++) begin
            if (b_xfer && (b_idx == SB'(i))) b_mask_nxt[i] = 1'b1;
        end
    end

`ifdef DEMUX_SCATTER_RANGE_ERR_EN
    logic a_oor;
    logic b_oor;
    assign a_oor = a_xfer && !auto_mode && (32'(a_sel) >= 32'(NA));
    assign b_oor = b_xfer && !auto_mode && (32'(b_sel) >= 32'(NB));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            a_flat <= '0;
            b_flat <= '0;
            a_mask <= '0;
            b_mask <= '0;
            a_ptr  <= '0;
            b_ptr  <= '0;
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
            sel_err <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    for (int i = 0; i < NA; i++) begin
                        if (a_xfer && (a_idx == SA'(i))) a_flat[i*DW +: DW] <= a_data;
                    end
                    for (int i = 0; i < NB; i++) begin
                        if (b_xfer && (b_idx == SB'(i))) b_flat[i*DW +: DW] <= b_data;
                    end
                    a_mask <= a_mask_nxt;
                    b_mask <= b_mask_nxt;
                    if (a_xfer && auto_mode)
                        a_ptr <= (a_ptr == SA'(NA-1)) ? '0 : a_ptr + 1'b1;
                    if (b_xfer && auto_mode)
                        b_ptr <= (b_ptr == SB'(NB-1)) ? '0 : b_ptr + 1'b1;
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
                    if (a_oor || b_oor) sel_err <= 1'b1;
`endif
                    if (&a_mask_nxt && &b_mask_nxt) state <= HOLD;
                end
                HOLD: begin
                    // Bank data is kept on ack; only the bookkeeping restarts.
                    if (frame_ack) begin
                        a_mask <= '0;
                        b_mask <= '0;
                        a_ptr  <= '0;
                        b_ptr  <= '0;
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
                        sel_err <= 1'b0;
`endif
                        state  <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scatter_reg.sv
// Bench for demux_scatter_reg: directed frames plus randomized traffic against an array-based model.
module tb_demux_scatter_reg;
    localparam int DW = 16;
    localparam int NA = 4;
    localparam int NB = 6;
    localparam int SA = 2;
    localparam int SB = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             auto_mode;
    logic             a_valid;
    logic             a_ready;
    logic [SA-1:0]    a_sel;
    logic [DW-1:0]    a_data;
    logic             b_valid;
    logic             b_ready;
    logic [SB-1:0]    b_sel;
    logic [DW-1:0]    b_data;
    logic [NA*DW-1:0] a_flat;
    logic [NB*DW-1:0] b_flat;
    logic [NA-1:0]    a_mask;
    logic [NB-1:0]    b_mask;
    logic             frame_valid;
    logic             frame_ack;
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
    logic             sel_err;
`endif

    demux_scatter_reg #(.DW(DW), .NA(NA), .NB(NB), .SA(SA), .SB(SB)) dut (
        .clk(clk), .rst_n(rst_n), .auto_mode(auto_mode),
        .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_data(b_data),
        .a_flat(a_flat), .b_flat(b_flat), .a_mask(a_mask), .b_mask(b_mask),
        .frame_valid(frame_valid), .frame_ack(frame_ack)
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: element arrays, written-flags, pointers, frame-held flag.
    logic [DW-1:0] ma [NA];
    logic [DW-1:0] mb [NB];
    bit            mam [NA];
    bit            mbm [NB];
    int            pa, pb;
    bit            mhold;
    bit            merr;

    function automatic bit all_set_a();
        for (int i = 0; i < NA; i++) if (!mam[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_set_b();
        for (int i = 0; i < NB; i++) if (!mbm[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin ma[i] = '0; mam[i] = 1'b0; end
        for (int i = 0; i < NB; i++) begin mb[i] = '0; mbm[i] = 1'b0; end
        pa = 0; pb = 0; mhold = 1'b0; merr = 1'b0;
    endfunction

    function automatic void model_edge();
        int ia, ib;
        if (mhold) begin
            if (frame_ack) begin
                for (int i = 0; i < NA; i++) mam[i] = 1'b0;
                for (int i = 0; i < NB; i++) mbm[i] = 1'b0;
                pa = 0; pb = 0; mhold = 1'b0; merr = 1'b0;
            end
        end else begin
            if (a_valid) begin
                ia = auto_mode ? pa : int'(a_sel);
                if (ia < NA) begin ma[ia] = a_data; mam[ia] = 1'b1; end
                else merr = 1'b1;
                if (auto_mode) pa = (pa + 1) % NA;
            end
            if (b_valid) begin
                ib = auto_mode ? pb : int'(b_sel);
                if (ib < NB) begin mb[ib] = b_data; mbm[ib] = 1'b1; end
                else merr = 1'b1;
                if (auto_mode) pb = (pb + 1) % NB;
            end
            if (all_set_a() && all_set_b()) mhold = 1'b1;
        end
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] ea, eb, eam, ebm;
        ea = '0; eb = '0; eam = '0; ebm = '0;
        for (int i = 0; i < NA; i++) begin ea[i*DW +: DW] = ma[i]; eam[i] = mam[i]; end
        for (int i = 0; i < NB; i++) begin eb[i*DW +: DW] = mb[i]; ebm[i] = mbm[i]; end
        chk("a_ready", a_ready, !mhold);
        chk("b_ready", b_ready, !mhold);
        chk("frame_valid", frame_valid, mhold);
        chk("a_mask", a_mask, eam);
        chk("b_mask", b_mask, ebm);
        if (mhold) begin
            chk("a_flat", a_flat, ea);
            chk("b_flat", b_flat, eb);
        end else begin
            for (int i = 0; i < NA; i++) if (mam[i]) chk("a_elem", a_flat[i*DW +: DW], ma[i]);
            for (int i = 0; i < NB; i++) if (mbm[i]) chk("b_elem", b_flat[i*DW +: DW], mb[i]);
        end
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
        chk("sel_err", sel_err, merr);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0; frame_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; auto_mode = 1'b0; idle();
        a_sel = '0; b_sel = '0; a_data = '0; b_data = '0;
        model_reset();
        #12;
        check_all();
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_a_flat", a_flat, '0);
        rst_n = 1'b1;

        // Manual frame
        for (int i = 0; i < NB; i++) begin
            a_valid = (i < NA);
            a_sel   = SA'(i % NA);
            a_data  = 16'h0011 * 16'(i + 1);
            b_valid = 1'b1;
            b_sel   = SB'(i);
            b_data  = 16'h0100 + 16'(i);
            step();
            if (i == NB - 2) chk("m_fv_early", frame_valid, 1'b0);
        end
        idle();
        chk("m_fv", frame_valid, 1'b1);
        chk("m_ready", a_ready, 1'b0);
        chk("m_aflat", a_flat, 64'h0044_0033_0022_0011);
        chk("m_bflat", b_flat, 96'h0105_0104_0103_0102_0101_0100);

        // Valid held during HOLD must not transfer
        auto_mode = 1'b1; a_valid = 1'b1; a_data = 16'hBEEF;
        step(); step();
        chk("hold_aflat", a_flat, 64'h0044_0033_0022_0011);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("ack_fv", frame_valid, 1'b0);
        chk("ack_amask", a_mask, 4'b0000);
        step();
        chk("beef_elem0", a_flat[15:0], 16'hBEEF);
        chk("beef_mask", a_mask, 4'b0001);

        // Complete that frame by streaming
        for (int c = 0; c < NB; c++) begin
            a_valid = (c < 3); a_data = 16'h0301 + 16'(c);
            b_valid = 1'b1;    b_data = 16'h0200 + 16'(c);
            step();
        end
        idle();
        chk("s1_fv", frame_valid, 1'b1);
        chk("s1_aflat", a_flat, 64'h0303_0302_0301_BEEF);
        chk("s1_bflat", b_flat, 96'h0205_0204_0203_0202_0201_0200);
        frame_ack = 1'b1; step(); frame_ack = 1'b0;

        // Fresh concurrent stream: frame completes on the 6th B transfer
        for (int c = 0; c < NB; c++) begin
            a_valid = (c < NA); a_data = 16'h0A00 + 16'(c);
            b_valid = 1'b1;     b_data = 16'h0B00 + 16'(c);
            step();
            chk("s2_fv", frame_valid, (c == NB - 1));
        end
        idle();
        chk("s2_bflat", b_flat, 96'h0B05_0B04_0B03_0B02_0B01_0B00);
        frame_ack = 1'b1; step(); frame_ack = 1'b0;

        // Out-of-range manual writes on B
        auto_mode = 1'b0; b_valid = 1'b1; b_data = 16'hDEAD;
        b_sel = 3'd6; step();
        chk("oor_ready", b_ready, 1'b1);
        b_sel = 3'd7; step();
        idle();
        chk("oor_bmask", b_mask, 6'b000000);
        chk("oor_fv", frame_valid, 1'b0);
`ifdef DEMUX_SCATTER_RANGE_ERR_EN
        chk("oor_err", sel_err, 1'b1);
`endif

        // Rewrite of the same element
        a_valid = 1'b1; a_sel = 2'd2;
        a_data = 16'h1111; step();
        a_data = 16'h2222; step();
        chk("rw_elem2", a_flat[47:32], 16'h2222);
        chk("rw_mask", a_mask, 4'b0100);
        a_sel = 2'd0; step();
        a_sel = 2'd1; step();
        idle();
        chk("rw_mask3", a_mask, 4'b0111);

        // Asynchronous reset mid-frame
        #2; rst_n = 1'b0; #1;
        model_reset();
        check_all();
        chk("arst_amask", a_mask, 4'b0000);
        chk("arst_aflat", a_flat, 64'h0);
        #1; rst_n = 1'b1;
        for (int i = 0; i < NB; i++) begin
            a_valid = (i < 3); a_sel = SA'(i); a_data = 16'h0C00 + 16'(i);
            b_valid = 1'b1;    b_sel = SB'(i); b_data = 16'h0D00 + 16'(i);
            step();
        end
        idle();
        chk("arst_fv0", frame_valid, 1'b0);
        a_valid = 1'b1; a_sel = 2'd3; a_data = 16'h0C03; step();
        idle();
        chk("arst_fv1", frame_valid, 1'b1);
        frame_ack = 1'b1; step(); frame_ack = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            auto_mode = ($urandom_range(0, 3) != 0);
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            a_sel     = SA'($urandom_range(0, 3));
            b_sel     = SB'($urandom_range(0, 7));
            a_data    = DW'($urandom);
            b_data    = DW'($urandom);
            frame_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
